// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: operand/result bundle with start/ready/done handshake for the mul/div unit
interface alu_muldiv_if #(parameter int N = 32, parameter int Ctr_size = 3);
  logic                start;
  logic [Ctr_size-1:0] op;
  logic [N-1:0]        ADin;
  logic [N-1:0]        BDin;
  logic                ready;
  logic                done;
  logic [N-1:0]        Result;
  logic [N-1:0]        HI;
  logic [N-1:0]        LO;
  logic                Zero;
  logic                DivZero;
  modport master(output start, op, ADin, BDin, input ready, done, Result, HI, LO, Zero, DivZero);
  modport slave(input start, op, ADin, BDin, output ready, done, Result, HI, LO, Zero, DivZero);
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative one-bit-per-clock multiply/divide unit with HI/LO register moves
module alu_muldiv #(
  parameter int N        = 32,
  parameter int Ctr_size = 3
) (
  input logic         clk,
  input logic         reset,
  alu_muldiv_if.slave bus
);
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, RUN, FIX, MOVE} state_t;
  state_t          r_state;
  logic [2:0]      r_op;
  logic [N-1:0]    r_a, r_b, r_wh, r_wl, r_hi, r_lo, r_res;
  logic            r_sa, r_sb, r_ready, r_done, r_dz;
  logic [CW-1:0]   r_cnt;
  logic            w_sa, w_sb, w_ge, w_dz;
  logic [N-1:0]    w_ma, w_mb, w_nh, w_nl, w_q, w_r;
  logic [N:0]      w_sum, w_t, w_diff;
  logic [2*N-1:0]  w_prod;
  // operand magnitudes at acceptance, one shift-add / restoring step, and sign fix-up
  always_comb begin
    w_sa   = ~bus.op[0] & bus.ADin[N-1];
    w_sb   = ~bus.op[0] & bus.BDin[N-1];
    w_ma   = w_sa ? -bus.ADin : bus.ADin;
    w_mb   = w_sb ? -bus.BDin : bus.BDin;
    w_sum  = {1'b0, r_wh} + {1'b0, r_b};
    w_t    = {r_wh, r_wl[N-1]};
    w_ge   = w_t >= {1'b0, r_b};
    w_diff = w_t - {1'b0, r_b};
    w_nh   = r_op[1] ? (w_ge ? w_diff[N-1:0] : w_t[N-1:0])
                     : (r_wl[0] ? w_sum[N:1] : {1'b0, r_wh[N-1:1]});
    w_nl   = r_op[1] ? {r_wl[N-2:0], w_ge}
                     : {(r_wl[0] ? w_sum[0] : r_wh[0]), r_wl[N-1:1]};
    w_prod = (r_sa ^ r_sb) ? -{r_wh, r_wl} : {r_wh, r_wl};
    w_dz   = r_b == '0;
    w_q    = w_dz ? '1 : (r_sa ^ r_sb) ? -r_wl : r_wl;
    w_r    = w_dz ? r_a : r_sa ? -r_wh : r_wh;
  end
  // control FSM; HI/LO/Result only change in FIX or MOVE so partial results never leak
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_res   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dz    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_ready <= 1'b0;
          r_op    <= bus.op[2:0];
          r_a     <= bus.ADin;
          r_sa    <= w_sa;
          r_sb    <= w_sb;
          r_wh    <= '0;
          r_wl    <= w_ma;
          r_b     <= w_mb;
          r_cnt   <= '0;
          r_state <= bus.op[2] ? MOVE : RUN;
        end
        RUN: begin
          r_wh  <= w_nh;
          r_wl  <= w_nl;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) r_state <= FIX;
        end
        FIX: begin
          {r_hi, r_lo} <= r_op[1] ? {w_r, w_q} : w_prod;
          r_dz    <= r_op[1] & w_dz;
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          if (r_op[1] & r_op[0]) r_lo <= r_a;
          if (r_op[1] & ~r_op[0]) r_hi <= r_a;
          if (~r_op[1]) r_res <= r_op[0] ? r_lo : r_hi;
          r_dz    <= 1'b0;
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end
  assign bus.ready   = r_ready;
  assign bus.done    = r_done;
  assign bus.Result  = r_res;
  assign bus.HI      = r_hi;
  assign bus.LO      = r_lo;
  assign bus.DivZero = r_dz;
  assign bus.Zero    = ~|r_res;
endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised sequential multiply/divide unit that extends the combinational MIPS-like ALU with MULT, MULTU, DIV and DIVU. It also provides the HI/LO register moves MFHI, MFLO, MTHI and MTLO. It sits beside the ALU in the execute stage. It exchanges operands and results with the pipeline through a start/ready/done handshake. Multiply and divide are iterative, one bit per clock, with a fixed and deterministic latency.

## Interface
- `N`, 32, operand width in bits; must be ≥ 4.
- `Ctr_size`, 3, width of the `op` field.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request; accepted only when `ready`=1.
- `op`  in  Ctr_size  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MFHI, 101 MFLO, 110 MTHI, 111 MTLO.
- `ADin`  in  N  operand A, sampled only at acceptance.
- `BDin`  in  N  operand B, sampled only at acceptance.
- `ready`  out  1  unit can accept a request this cycle.
- `done`  out  1  single-cycle pulse marking operation completion.
- `Result`  out  N  registered MFHI/MFLO value; holds between moves.
- `HI`  out  N  HI register: product upper half, or remainder.
- `LO`  out  N  LO register: product lower half, or quotient.
- `Zero`  out  1  `~|Result`, combinational from `Result`.
- `DivZero`  out  1  last completed DIV/DIVU had `BDin`=0; cleared by the next completed op.

## Operation
- Acceptance edge: rising edge with `start`=1 and `ready`=1. `op`, `ADin` and `BDin` are latched at this edge.
- States:
  - IDLE -> RUN on acceptance of ops 000–011.
  - IDLE -> MOVE on acceptance of ops 100–111.
  - RUN -> FIX after exactly N iterations; a log2(N)+1-bit counter tracks iterations.
  - FIX -> IDLE.
  - MOVE -> IDLE.
- Signed ops (MULT, DIV): magnitudes are taken at acceptance; the core then runs unsigned.
- MULT result sign: the 2N-bit product is negated in FIX when sA^sB.
- DIV result signs: quotient negated when sA^sB; remainder takes the sign of A.
- Multiply core: shift-add over the 2N-bit {HI,LO} accumulator; product is modulo 2^(2N).
- Divide core: restoring division. Quotient goes to LO, remainder to HI.
- Most-negative / −1: LO = most-negative (wraps), HI = 0, no error flag.
- Divide by zero: full latency is still used. Result is LO = all ones, HI = `ADin`, DivZero = 1.
- HI/LO are written only in FIX (mul/div) or MOVE (MTHI/MTLO). They are never partially visible; working registers are kept separate.
- MFHI/MFLO: `Result` ← HI/LO in MOVE. MTHI/MTLO: HI/LO ← latched `ADin`. `Result` is unchanged by MTHI/MTLO and by mul/div.
- `start` while `ready`=0 is ignored: no queueing, no state change.

## Timing
- Reset values, applied at the first edge with `reset`=1:
  - state = IDLE
  - `ready` = 1
  - `done` = 0
  - `Result` = 0
  - `HI` = 0, `LO` = 0
  - `DivZero` = 0
  - `Zero` = 1
- `reset` overrides everything, including mid-iteration and acceptance in the same cycle. Any in-flight operation is discarded and HI/LO are not updated.
- Mul/div latency: acceptance at edge E0, N iteration edges, FIX edge at E0+N+1. `done`=1 and updated HI/LO/DivZero are visible in the cycle after E0+N+1, i.e. N+1 cycles after acceptance.
- Move latency: MOVE edge is E0+1. `done` and the updated `Result`/HI/LO are visible in the cycle after that.
- `ready` is 0 from the cycle after acceptance through FIX/MOVE.
- `ready` returns to 1 in the `done` cycle. A new `start` in that cycle is accepted (back-to-back, no bubble).
- `done` is exactly one cycle wide and never asserted without a preceding acceptance.

## Test plan
- Reset, then MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; `done` pulse exactly 33 cycles after acceptance; `ready`=0 in between.
- MULT A=−3 (0xFFFFFFFD) B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIV −7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 -> LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0, DivZero=0.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5, DivZero=1 after 33 cycles. Following MTLO 9 -> DivZero=0, LO=9.
- MTHI 0x1234, then MFHI -> Result=0x1234, Zero=0; each move takes 2 cycles to `done`. `start`=MFLO asserted during a busy MULT is ignored (Result unchanged). A new MULT asserted in the `done` cycle is accepted.
- Assert `reset` 10 cycles into a DIVU that follows a completed MULT -> next cycle HI=LO=0, Result=0, ready=1, done=0, and no `done` pulse ever appears for the aborted DIVU.
